alu_share_arbiter: RTL
======================

# alu_share_arbiter

Sequencer that shares one 32-bit ALU (bitwise AND, OR, ADD, SUB) between two requesters. It arbitrates round-robin, captures the winner's operands and opcode, and executes one operation. It then returns a registered result with flags and the winner's ID. It sits between the lab's bit-sliced logic/arith units and the two datapath clients, so only one copy of the 32-bit datapath is instantiated.

## Interface
- WIDTH, 32, operand/result width (fixed at 32 for this lab; parameter kept for the bench)
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- req0 / req1  input  1  request from requester 0 / 1; held high with operands stable until matching gnt seen
- op0 / op1  input  2  opcode: 00 AND, 01 OR, 10 ADD, 11 SUB (a-b)
- a0, b0 / a1, b1  input  WIDTH  operands of requester 0 / 1
- gnt0 / gnt1  output  1  one-cycle pulse: request accepted, operands captured
- result  output  WIDTH  registered ALU result
- carry  output  1  ADD: carry out of bit 31; SUB: 1 = no borrow (a >= b unsigned); AND/OR: 0
- zero  output  1  1 when result == 0
- res_valid  output  1  one-cycle pulse: result/carry/zero/res_id are new
- res_id  output  1  requester that owns the current result
- busy  output  1  combinational: FSM not in IDLE

## Operation
- FSM states: IDLE, EXEC, DONE. Reset state: IDLE.
- IDLE:
  - req0/req1 sampled only in this state.
  - If any request is high, winner = sole requester, or on a tie the requester named by priority pointer `ptr`.
  - Latch winner's op, a, b, id. Pulse gnt<id>. Set `ptr` = other requester. Go to EXEC.
  - If no request is high, stay in IDLE.
- EXEC: compute on latched operands and register result, carry, zero and res_id. Go to DONE.
- DONE: res_valid = 1. Go to IDLE unconditionally.
- Arithmetic is modulo 2^32. SUB is a + ~b + 1; carry is bit 32 of that sum.
- result, carry, zero and res_id hold their values until the next EXEC->DONE update.
- Requester protocol:
  - Drop req (or present a new op) on the edge after gnt is seen.
  - If req is still high when the FSM returns to IDLE, it counts as a new request.
- A losing requester keeps req high and is served on the next IDLE visit. With two active requesters, grants strictly alternate.
- Reset mid-operation (any state): the operation is abandoned, no res_valid is produced, `ptr` returns to 0, and all outputs return to their reset values immediately.

## Timing
- Reset values: gnt0 = gnt1 = 0, res_valid = 0, result = 0, carry = 0, zero = 0, res_id = 0, busy = 0, `ptr` = 0 (requester 0 wins the first tie).
- Let edge k be the one where the FSM in IDLE samples a request:
  - gnt<id> is high in cycle k..k+1.
  - Result is registered at edge k+1; res_valid is high in cycle k+1..k+2.
  - FSM is back in IDLE after edge k+2.
  - The next grant can be sampled no earlier than edge k+3.
- Throughput: one operation per 3 cycles. Latency from accepting edge to res_valid: 1 cycle.
- gnt, res_valid, result and flags are all registered outputs; only busy is combinational from state.
- gnt0 and gnt1 are never high in the same cycle. res_valid is never high for two consecutive cycles.

## Test plan
- Reset: drive rst_n = 0 asynchronously mid-cycle with req0 = 1 -> all outputs 0 immediately, and no gnt while rst_n = 0.
- Single AND: req0, op0 = 00, a0 = 32'h0000A5A5, b0 = 32'h00005A5A -> gnt0 one cycle after the sampling edge, then res_valid with result = 0, zero = 1, carry = 0, res_id = 0.
- Tie after reset:
  - Stimulus: req0 (OR, 32'h0000A5A5 | 32'h00005A5A) and req1 (ADD, 32'hFFFFFFFF + 1) raised together.
  - Required response: gnt0 first, with result = 32'h0000FFFF, zero = 0, res_id = 0.
  - Then gnt1 exactly 3 cycles after gnt0, with result = 0, carry = 1, zero = 1, res_id = 1.
- Fairness: req0 and req1 held high for 12 cycles -> gnt sequence 0, 1, 0, 1 at 3-cycle spacing, with no double grant.
- SUB flags:
  - 5 - 7 -> result = 32'hFFFFFFFE, carry = 0, zero = 0.
  - 7 - 5 -> result = 2, carry = 1.
  - 9 - 9 -> result = 0, carry = 1, zero = 1.
- Reset during EXEC:
  - Stimulus: pulse rst_n low in the cycle after gnt1, then release and hold both requests.
  - Required response: no res_valid for the aborted operation, and requester 0 wins the next tie.

Source files
------------

// File: rtl/alu_share_arbiter.sv
// One shared 32-bit ALU (AND/OR/ADD/SUB) serving two requesters with round-robin arbitration.
// Each operation takes three cycles: grant/capture, execute, then result-valid.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             res_valid,
  output logic             res_id,
  output logic             busy
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e           state_q, state_d;
  logic             ptr_q, ptr_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             id_q, id_d;
  logic             gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_q, carry_d, zero_q, zero_d, res_id_q, res_id_d;
  logic             win;

  // SUB reuses the adder as a + ~b + 1; bit WIDTH is carry (ADD) or no-borrow (SUB).
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry;

  assign sum = {1'b0, a_q} + {1'b0, (op_q[0] ? ~b_q : b_q)} + {{WIDTH{1'b0}}, op_q[0]};

  always_comb begin
    alu_res   = sum[WIDTH-1:0];
    alu_carry = op_q[1] & sum[WIDTH];
    case (op_q)
      2'b00:   alu_res = a_q & b_q;
      2'b01:   alu_res = a_q | b_q;
      default: alu_res = sum[WIDTH-1:0];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    res_valid_d = 1'b0;
    result_d    = result_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    res_id_d    = res_id_q;
    // Sole requester wins; on a tie the pointer decides.
    win         = (req0 && req1) ? ptr_q : req1;
    unique case (state_q)
      StIdle: begin
        if (req0 || req1) begin
          op_d    = win ? op1 : op0;
          a_d     = win ? a1 : a0;
          b_d     = win ? b1 : b0;
          id_d    = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
          ptr_d   = ~win;
          state_d = StExec;
        end
      end
      StExec: begin
        result_d    = alu_res;
        carry_d     = alu_carry;
        zero_d      = (alu_res == '0);
        res_id_d    = id_q;
        res_valid_d = 1'b1;
        state_d     = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= 1'b0;
      op_q        <= 2'b00;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      res_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      res_id_q    <= res_id_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign res_valid = res_valid_q;
  assign result    = result_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign res_id    = res_id_q;
  assign busy      = (state_q != StIdle);

endmodule
